// File: rtl/wallace_cpa_pipe.sv
// Final carry-propagate adder of the 8x8 Wallace multiplier: sum row + carry row,
// split into two registered ripple stages with a valid/ready handshake.
module wallace_cpa_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPLIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] product,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned HI = WIDTH - SPLIT;

    logic             r_s1_valid;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_c1;
    logic [HI-1:0]    r_s1_hi_sum;
    logic [HI-1:0]    r_s1_hi_carry;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_product;
    logic             r_ovf;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [SPLIT-1:0] w_lo;
    logic             w_c1;
    logic [HI-1:0]    w_hi;
    logic             w_c2;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // Low ripple chain: bit 0 has no carry-in, so it reduces to a half adder.
    always_comb begin : lo_adder
        logic c;
        c    = 1'b0;
        w_lo = '0;
        for (int unsigned i = 0; i < SPLIT; i++) begin
            w_lo[i] = sum_vec[i] ^ carry_vec[i] ^ c;
            c       = (sum_vec[i] & carry_vec[i]) | (c & (sum_vec[i] ^ carry_vec[i]));
        end
        w_c1 = c;
    end

    // High ripple chain, seeded with the registered carry out of the low half.
    always_comb begin : hi_adder
        logic c;
        c    = r_s1_c1;
        w_hi = '0;
        for (int unsigned i = 0; i < HI; i++) begin
            w_hi[i] = r_s1_hi_sum[i] ^ r_s1_hi_carry[i] ^ c;
            c       = (r_s1_hi_sum[i] & r_s1_hi_carry[i]) |
                      (c & (r_s1_hi_sum[i] ^ r_s1_hi_carry[i]));
        end
        w_c2 = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_lo       <= '0;
            r_s1_c1       <= 1'b0;
            r_s1_hi_sum   <= '0;
            r_s1_hi_carry <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_lo       <= w_lo;
                r_s1_c1       <= w_c1;
                r_s1_hi_sum   <= sum_vec[WIDTH-1:SPLIT];
                r_s1_hi_carry <= carry_vec[WIDTH-1:SPLIT];
            end
        end
    end

    // Output register doubles as stage 2; it empties when drained with no stage-1 item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_product  <= '0;
            r_ovf      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= {w_hi, r_s1_lo};
                r_ovf     <= w_c2;
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign product   = r_product;
    assign ovf       = r_ovf;
    assign out_valid = r_s2_valid;

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// Bench for wallace_cpa_pipe: directed handshake scenarios plus randomized
// traffic checked against a queue of plain 17-bit sums.
module tb_wallace_cpa_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] sum_vec;
    logic [15:0] carry_vec;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] exp_q[$];
    bit          had_stall = 1'b0;
    logic [16:0] held;

    wallace_cpa_pipe #(.WIDTH(16), .SPLIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; samples, then advances one clock.
    task automatic cycle(output bit fired, output logic [16:0] p, output bit acc);
        logic [16:0] e;
        #1;
        fired = (out_valid === 1'b1) && (out_ready === 1'b1);
        p     = {ovf, product};
        acc   = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (had_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(p), 32'(held));
        end
        had_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        held      = p;
        if (fired) begin
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("scoreboard", 32'(p), 32'(e));
            end
        end
        if (acc) exp_q.push_back({1'b0, sum_vec} + {1'b0, carry_vec});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_item(input logic [15:0] s, input logic [15:0] c);
        bit f, a;
        logic [16:0] p;
        sum_vec   = s;
        carry_vec = c;
        in_valid  = 1'b1;
        a = 1'b0;
        for (int k = 0; k < 50 && !a; k++) cycle(f, p, a);
        chk("accept_bound", 32'(a), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [16:0] exp);
        bit f, a;
        logic [16:0] p;
        f = 1'b0;
        for (int k = 0; k < 10 && !f; k++) cycle(f, p, a);
        chk({tag, "_seen"}, 32'(f), 32'd1);
        chk(tag, 32'(p), 32'(exp));
    endtask

    task automatic drain();
        bit f, a;
        logic [16:0] p;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(f, p, a);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit          f, a, pend;
        logic [16:0] p;
        bit          fr[6];
        logic [16:0] pr[6];
        int          cnt;
        logic [15:0] s, c, pa, pb;

        rst_n     = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 1: two-cycle latency
        out_ready = 1'b1;
        sum_vec   = 16'hF000;
        carry_vec = 16'h0E01;
        in_valid  = 1'b1;
        cycle(f, p, a);
        chk("t1_accept", 32'(a), 32'd1);
        in_valid = 1'b0;
        #1;
        chk("t1_lat1_valid", 32'(out_valid), 32'd0);
        cycle(f, p, a);
        #1;
        chk("t1_lat2_valid", 32'(out_valid), 32'd1);
        chk("t1_product", 32'({ovf, product}), 32'h0FE01);
        drain();

        // 2, 3: carry across split, overflow
        push_item(16'h00FF, 16'h0001);
        wait_out("t2_split_carry", 17'h00100);
        drain();
        push_item(16'hFFFF, 16'h0001);
        wait_out("t3_ovf", 17'h10000);
        drain();

        // 4: back-to-back throughput
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                sum_vec   = 16'(2 * k + 1);
                carry_vec = 16'(2 * k + 2);
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle(fr[k], pr[k], a);
            if (k < 4) chk("t4_accept", 32'(a), 32'd1);
        end
        chk("t4_c0_idle", 32'(fr[0]), 32'd0);
        chk("t4_c1_idle", 32'(fr[1]), 32'd0);
        for (int k = 2; k < 6; k++) begin
            chk("t4_fire", 32'(fr[k]), 32'd1);
            chk("t4_value", 32'(pr[k]), 32'(4 * (k - 2) + 3));
        end

        // 5: stall with three items
        out_ready = 1'b0;
        sum_vec = 16'h0010; carry_vec = 16'h0020; in_valid = 1'b1;
        cycle(f, p, a);
        chk("t5_acc_a", 32'(a), 32'd1);
        sum_vec = 16'h1000; carry_vec = 16'h0234;
        cycle(f, p, a);
        chk("t5_acc_b", 32'(a), 32'd1);
        sum_vec = 16'hFFFF; carry_vec = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            cycle(f, p, a);
            chk("t5_full_in_ready", 32'(a), 32'd0);
            chk("t5_held", 32'(p), 32'h00030);
        end
        out_ready = 1'b1;
        cycle(f, p, a);
        chk("t5_simul_accept", 32'(a), 32'd1);
        chk("t5_simul_out", 32'(p), 32'h00030);
        in_valid = 1'b0;
        cnt = 1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            cycle(f, p, a);
            if (f) begin
                cnt++;
                chk("t5_order", 32'(p), (cnt == 2) ? 32'h01234 : 32'h10001);
            end
        end
        chk("t5_count", 32'(cnt), 32'd3);

        // 6: asynchronous reset with items in flight
        out_ready = 1'b0;
        sum_vec = 16'h0101; carry_vec = 16'h0202; in_valid = 1'b1;
        cycle(f, p, a);
        sum_vec = 16'h0303;
        cycle(f, p, a);
        in_valid = 1'b0;
        #1;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_product", 32'({ovf, product}), 32'd0);
        exp_q.delete();
        had_stall = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(f, p, a);
            chk("t6_no_stale", 32'(f), 32'd0);
        end

        // 8x8 products: corner operands then random pairs, each as a*b+0 and a random split
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                pa = (i == 0) ? 16'd0 : (i == 1) ? 16'd1 : (i == 2) ? 16'd2 : (i == 3) ? 16'd127 :
                     (i == 4) ? 16'd128 : (i == 5) ? 16'd254 : 16'd255;
                pb = (j == 0) ? 16'd0 : (j == 1) ? 16'd1 : (j == 2) ? 16'd2 : (j == 3) ? 16'd127 :
                     (j == 4) ? 16'd128 : (j == 5) ? 16'd254 : 16'd255;
                s = pa * pb;
                push_item(s, 16'd0);
                c = 16'($urandom_range(0, 32'(s)));
                push_item(s - c, c);
            end
        end
        for (int n = 0; n < 1500; n++) begin
            pa = 16'($urandom_range(0, 255));
            pb = 16'($urandom_range(0, 255));
            s  = pa * pb;
            push_item(s, 16'd0);
            c = 16'($urandom_range(0, 32'(s)));
            push_item(s - c, c);
        end
        drain();

        // Random traffic with random backpressure; full 16-bit rows exercise ovf
        pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    sum_vec   = 16'($urandom);
                    carry_vec = 16'($urandom);
                    in_valid  = 1'b1;
                    pend      = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(f, p, a);
            if (a) pend = 1'b0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
